ucsbece154b_fifo_flush: RTL and testbench



---
 rtl/ucsbece154b_fifo_flush.sv | 111 +++++++++++
 tb/tb_ucsbece154b_fifo_flush.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154b_fifo_flush.sv
// ucsbece154b_fifo_flush
//   Single-issue synchronous FIFO used as the fetch/instruction queue between
//   fetch and decode. Supports any depth (not only powers of two), reports
//   occupancy and a programmable almost-full level, and provides a one-cycle
//   flush for branch-mispredict recovery. A push is accepted while full when
//   a pop happens in the same cycle.
//
//   Optional feature (macro UCSBECE154B_FIFO_BYPASS_EN): when the queue is
//   empty, a push is shown on data_o/valid_o in the same cycle. If it is also
//   popped, it is consumed directly and never written.
//
// Ports
//   clk_i          clock, all state updates on posedge
//   rst_i          synchronous active-high reset (highest priority)
//   flush_i        discard all entries this cycle (priority over push/pop)
//   data_i         push data
//   push_i         push request
//   data_o         head entry (zero when empty)
//   pop_i          pop request, consumes the head at posedge
//   full_o         count == NR_ENTRIES
//   almost_full_o  count >= AFULL_THRESH
//   valid_o        head entry valid
//   count_o        current occupancy
module ucsbece154b_fifo_flush #(
  parameter int DATA_WIDTH   = 32,
  parameter int NR_ENTRIES   = 4,
  parameter int AFULL_THRESH = NR_ENTRIES - 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic [DATA_WIDTH-1:0]             data_i,
  input  logic                              push_i,
  output logic [DATA_WIDTH-1:0]             data_o,
  input  logic                              pop_i,
  output logic                              full_o,
  output logic                              almost_full_o,
  output logic                              valid_o,
  output logic [$clog2(NR_ENTRIES+1)-1:0]   count_o
);

  localparam int PTR_W = ($clog2(NR_ENTRIES) > 1) ? $clog2(NR_ENTRIES) : 1;
  localparam int CNT_W = $clog2(NR_ENTRIES + 1);

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NR_ENTRIES);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THRESH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(NR_ENTRIES - 1);

  logic [DATA_WIDTH-1:0] r_mem [NR_ENTRIES];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  logic                  w_nonempty;
  logic                  w_full;
  logic                  w_pop_en;
  logic                  w_push_en;
  logic                  w_byp_take;
  logic [DATA_WIDTH-1:0] w_head_data;

  // Explicit wrap so non-power-of-two depths never rely on 2^n overflow.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Full/empty come from the counter only; head==tail is ambiguous.
  assign w_nonempty    = (r_count != '0);
  assign w_full        = (r_count == FULL_CNT);
  assign full_o        = w_full;
  assign almost_full_o = (r_count >= AFULL_CNT);
  assign count_o       = r_count;
  assign w_head_data   = w_nonempty ? r_mem[r_head] : '0;

`ifdef UCSBECE154B_FIFO_BYPASS_EN
  logic w_byp;
  assign w_byp      = !w_nonempty && push_i && !flush_i;
  assign w_byp_take = w_byp && pop_i;
  assign valid_o    = w_nonempty || w_byp;
  assign data_o     = w_byp ? data_i : w_head_data;
`else
  assign w_byp_take = 1'b0;
  assign valid_o    = w_nonempty;
  assign data_o     = w_head_data;
`endif

  assign w_pop_en  = pop_i && w_nonempty;
  // A word consumed through the bypass is never written into storage.
  assign w_push_en = push_i && (!w_full || w_pop_en) && !w_byp_take;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_en) r_tail <= ptr_inc(r_tail);
      if (w_pop_en)  r_head <= ptr_inc(r_head);
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and counter define contents.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && w_push_en) r_mem[r_tail] <= data_i;
  end

endmodule

// File: tb/tb_ucsbece154b_fifo_flush.sv
module tb_ucsbece154b_fifo_flush;

  logic        clk = 1'b0;
  logic        rst, flush, push, pop;
  logic [31:0] din;

  logic [31:0] d4, d5;
  logic        f4, f5, a4, a5, v4, v5;
  logic [2:0]  c4, c5;

  logic        sel5;
  logic [31:0] o_data;
  logic        o_full, o_afull, o_valid;
  logic [2:0]  o_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ucsbece154b_fifo_flush #(.DATA_WIDTH(32), .NR_ENTRIES(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(din), .push_i(push),
    .data_o(d4), .pop_i(pop), .full_o(f4), .almost_full_o(a4),
    .valid_o(v4), .count_o(c4));

  ucsbece154b_fifo_flush #(.DATA_WIDTH(32), .NR_ENTRIES(5), .AFULL_THRESH(4)) dut5 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(din), .push_i(push),
    .data_o(d5), .pop_i(pop), .full_o(f5), .almost_full_o(a5),
    .valid_o(v5), .count_o(c5));

  assign o_data  = sel5 ? d5 : d4;
  assign o_full  = sel5 ? f5 : f4;
  assign o_afull = sel5 ? a5 : a4;
  assign o_valid = sel5 ? v5 : v4;
  assign o_count = sel5 ? c5 : c4;

  typedef struct {
    logic        push, pop, flush, rst;
    logic [31:0] din;
    logic [2:0]  ec;
    logic        ev, ef, ea;
    logic [31:0] ed;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] sb[$];
  int          cap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic pu, input logic po, input logic fl, input logic rs,
                     input logic [31:0] dd, input logic [2:0] ec, input logic ev,
                     input logic ef, input logic ea, input logic [31:0] ed);
    vec_t v;
    v.push = pu; v.pop = po; v.flush = fl; v.rst = rs; v.din = dd;
    v.ec = ec; v.ev = ev; v.ef = ef; v.ea = ea; v.ed = ed;
    tbl.push_back(v);
  endtask

  task automatic clear_in();
    push = 1'b0; pop = 1'b0; flush = 1'b0; rst = 1'b0; din = '0;
  endtask

  // Drive one cycle; scoreboard checks popped data before the edge,
  // table checks the registered state after it.
  task automatic step(input vec_t v, input int idx);
    bit can_push;
    push = v.push; pop = v.pop; flush = v.flush; rst = v.rst; din = v.din;
    #1;
    if (!v.rst && !v.flush && v.pop && sb.size() > 0)
      chk($sformatf("pop_data[%0d]", idx), o_data, sb[0]);
    if (v.rst || v.flush) begin
      sb.delete();
    end else begin
      can_push = v.push && (sb.size() < cap || (v.pop && sb.size() > 0));
      if (v.pop && sb.size() > 0) void'(sb.pop_front());
      if (can_push) sb.push_back(v.din);
    end
    @(posedge clk); #1;
    clear_in();
    #1;
    chk($sformatf("count[%0d]", idx), {29'd0, o_count}, {29'd0, v.ec});
    chk($sformatf("valid[%0d]", idx), {31'd0, o_valid}, {31'd0, v.ev});
    chk($sformatf("full[%0d]", idx),  {31'd0, o_full},  {31'd0, v.ef});
    chk($sformatf("afull[%0d]", idx), {31'd0, o_afull}, {31'd0, v.ea});
    chk($sformatf("data[%0d]", idx),  o_data, v.ed);
    chk($sformatf("sb_count[%0d]", idx), {29'd0, o_count}, sb.size());
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);
    tbl.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_in();
    sb.delete();
    #1;
  endtask

  initial begin
    clear_in();
    sel5 = 1'b0;
    cap  = 4;
    do_reset();

    // reset values of both instances
    chk("rst_valid4", {31'd0, v4}, 0);  chk("rst_full4", {31'd0, f4}, 0);
    chk("rst_afull4", {31'd0, a4}, 0);  chk("rst_count4", {29'd0, c4}, 0);
    chk("rst_data4", d4, 0);            chk("rst_count5", {29'd0, c5}, 0);
    chk("rst_valid5", {31'd0, v5}, 0);  chk("rst_data5", d5, 0);

    //  push pop fl rst data      cnt v f a  data_o
    // basic push x3, pop x3
    add(1, 0, 0, 0, 32'hA1,     1, 1,0,0, 32'hA1);
    add(1, 0, 0, 0, 32'hA2,     2, 1,0,0, 32'hA1);
    add(1, 0, 0, 0, 32'hA3,     3, 1,0,1, 32'hA1);
    add(0, 1, 0, 0, 0,          2, 1,0,0, 32'hA2);
    add(0, 1, 0, 0, 0,          1, 1,0,0, 32'hA3);
    add(0, 1, 0, 0, 0,          0, 0,0,0, 32'h0);
    // fill, then push+pop while full
    add(1, 0, 0, 0, 32'h1,      1, 1,0,0, 32'h1);
    add(1, 0, 0, 0, 32'h2,      2, 1,0,0, 32'h1);
    add(1, 0, 0, 0, 32'h3,      3, 1,0,1, 32'h1);
    add(1, 0, 0, 0, 32'h4,      4, 1,1,1, 32'h1);
    add(1, 0, 0, 0, 32'h9,      4, 1,1,1, 32'h1);   // dropped
    add(1, 1, 0, 0, 32'h5,      4, 1,1,1, 32'h2);
    add(0, 1, 0, 0, 0,          3, 1,0,1, 32'h3);
    add(0, 1, 0, 0, 0,          2, 1,0,0, 32'h4);
    add(0, 1, 0, 0, 0,          1, 1,0,0, 32'h5);
    add(0, 1, 0, 0, 0,          0, 0,0,0, 32'h0);
    // flush with a concurrent push
    add(1, 0, 0, 0, 32'h11,     1, 1,0,0, 32'h11);
    add(1, 0, 0, 0, 32'h22,     2, 1,0,0, 32'h11);
    add(1, 0, 0, 0, 32'h33,     3, 1,0,1, 32'h11);
    add(1, 0, 1, 0, 32'hFF,     0, 0,0,0, 32'h0);
    add(1, 0, 0, 0, 32'h77,     1, 1,0,0, 32'h77);
    add(0, 1, 0, 0, 0,          0, 0,0,0, 32'h0);
    // pops on empty, then reset during a push at count 2
    add(0, 1, 0, 0, 0,          0, 0,0,0, 32'h0);
    add(0, 1, 0, 0, 0,          0, 0,0,0, 32'h0);
    add(0, 1, 0, 0, 0,          0, 0,0,0, 32'h0);
    add(1, 0, 0, 0, 32'h44,     1, 1,0,0, 32'h44);
    add(1, 0, 0, 0, 32'h55,     2, 1,0,0, 32'h44);
    add(1, 0, 0, 1, 32'h33,     0, 0,0,0, 32'h0);
    add(0, 1, 0, 0, 0,          0, 0,0,0, 32'h0);
    add(1, 0, 0, 0, 32'h66,     1, 1,0,0, 32'h66);
    add(0, 1, 0, 0, 0,          0, 0,0,0, 32'h0);
    run_table();

    // 5-entry instance, threshold 4: overflow drops and pointer wrap
    do_reset();
    sel5 = 1'b1;
    cap  = 5;
    add(1, 0, 0, 0, 32'h10,     1, 1,0,0, 32'h10);
    add(1, 0, 0, 0, 32'h11,     2, 1,0,0, 32'h10);
    add(1, 0, 0, 0, 32'h12,     3, 1,0,0, 32'h10);
    add(1, 0, 0, 0, 32'h13,     4, 1,0,1, 32'h10);
    add(1, 0, 0, 0, 32'h14,     5, 1,1,1, 32'h10);
    add(1, 0, 0, 0, 32'h15,     5, 1,1,1, 32'h10);
    add(1, 0, 0, 0, 32'h16,     5, 1,1,1, 32'h10);
    add(0, 1, 0, 0, 0,          4, 1,0,1, 32'h11);
    add(0, 1, 0, 0, 0,          3, 1,0,0, 32'h12);
    add(0, 1, 0, 0, 0,          2, 1,0,0, 32'h13);
    add(0, 1, 0, 0, 0,          1, 1,0,0, 32'h14);
    add(0, 1, 0, 0, 0,          0, 0,0,0, 32'h0);
    add(1, 0, 0, 0, 32'h20,     1, 1,0,0, 32'h20);
    add(1, 0, 0, 0, 32'h21,     2, 1,0,0, 32'h20);
    add(1, 1, 0, 0, 32'h22,     2, 1,0,0, 32'h21);
    add(0, 1, 0, 0, 0,          1, 1,0,0, 32'h22);
    add(0, 1, 0, 0, 0,          0, 0,0,0, 32'h0);
    run_table();

    // empty-queue push: same-cycle visibility depends on the bypass build
    do_reset();
    sel5 = 1'b0;
    push = 1'b1; pop = 1'b1; din = 32'hBEEF;
    #1;
`ifdef UCSBECE154B_FIFO_BYPASS_EN
    chk("byp_take_valid", {31'd0, v4}, 1);
    chk("byp_take_data", d4, 32'hBEEF);
`else
    chk("nobyp_take_valid", {31'd0, v4}, 0);
    chk("nobyp_take_data", d4, 0);
`endif
    @(posedge clk); #1;
    clear_in();
    #1;
`ifdef UCSBECE154B_FIFO_BYPASS_EN
    chk("byp_take_count", {29'd0, c4}, 0);
    chk("byp_take_after", {31'd0, v4}, 0);
`else
    chk("nobyp_take_count", {29'd0, c4}, 1);
    chk("nobyp_take_after", d4, 32'hBEEF);
    do_reset();
`endif
    push = 1'b1; din = 32'hBEEF;
    #1;
`ifdef UCSBECE154B_FIFO_BYPASS_EN
    chk("byp_push_valid", {31'd0, v4}, 1);
`else
    chk("nobyp_push_valid", {31'd0, v4}, 0);
`endif
    @(posedge clk); #1;
    clear_in();
    #1;
    chk("empty_push_count", {29'd0, c4}, 1);
    chk("empty_push_valid", {31'd0, v4}, 1);
    chk("empty_push_data", d4, 32'hBEEF);
    repeat (2) @(posedge clk);
    #1;
    chk("empty_push_persist", d4, 32'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
